// File: rtl/clink_pkg.sv
// Shared C-link scheduler types and frame constants.
// Imported by clink_tx_sched and clink_rr_pick.
package clink_pkg;

  typedef enum logic [2:0] {
    IDLE,
    GRANT,
    START,
    WAIT_DONE,
    GAP
  } sched_state_e;

  localparam logic [10:0] HDR_BYTES     = 11'd11;
  localparam logic [10:0] PAYLOAD_BYTES = 11'd1024;
  localparam logic [10:0] MAX_FRAME_LEN = HDR_BYTES + PAYLOAD_BYTES;

endpackage

// File: rtl/clink_rr_pick.sv
// Round-robin first-set search over a request vector, starting at rr.
// Returns one-hot grant, its index and a valid flag.
module clink_rr_pick
  import clink_pkg::*;
#(
  parameter int N  = 2,
  parameter int IW = 1
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] rr_i,
  output logic [N-1:0]  gnt_o,
  output logic [IW-1:0] idx_o,
  output logic          vld_o
);

  int j;

  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    vld_o = 1'b0;
    j     = 0;
    for (int i = 0; i < N; i++) begin
      j = (int'(rr_i) + i) % N;
      if (!vld_o && req_i[j]) begin
        vld_o    = 1'b1;
        gnt_o[j] = 1'b1;
        idx_o    = IW'(j);
      end
    end
  end

endmodule

// File: rtl/clink_tx_sched.sv
// C-link tx buffer / MAC-start arbiter for NUM_CH frame builders.
// Optional counters: define CLINK_SCHED_STATS_EN.
module clink_tx_sched
  import clink_pkg::*;
#(
  parameter int          NUM_CH        = 2,
  parameter logic [10:0] MAX_LEN       = MAX_FRAME_LEN,
  parameter logic [15:0] GRANT_TIMEOUT = 16'd4096,
  parameter logic [15:0] DONE_TIMEOUT  = 16'd60000,
  parameter logic [7:0]  GAP_CYCLES    = 8'd16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NUM_CH-1:0]    ch_req,
  output logic [NUM_CH-1:0]    ch_gnt,
  input  logic [NUM_CH-1:0]    ch_wren,
  input  logic [NUM_CH*11-1:0] ch_waddr,
  input  logic [NUM_CH*8-1:0]  ch_wdata,
  input  logic [NUM_CH-1:0]    ch_start,
  input  logic [NUM_CH*11-1:0] ch_len,
  output logic [NUM_CH-1:0]    ch_done,
  output logic [NUM_CH-1:0]    ch_err,
  output logic                 tx_buf_wren,
  output logic [10:0]          tx_buf_waddr,
  output logic [7:0]           tx_buf_wdata,
  output logic                 tx_start,
  output logic [10:0]          tx_data_len,
  input  logic                 tx_done,
  output logic                 sched_busy
`ifdef CLINK_SCHED_STATS_EN
  ,
  output logic [15:0]          stat_frames,
  output logic [15:0]          stat_len_err,
  output logic [15:0]          stat_timeouts
`endif
);

  localparam int IW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  sched_state_e state_q, state_d;
  logic [NUM_CH-1:0] gnt_q, gnt_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic [IW-1:0]     rr_q, rr_d;
  logic [15:0]       timer_q, timer_d;
  logic [7:0]        gap_q, gap_d;
  logic              wren_q, wren_d;
  logic [10:0]       waddr_q, waddr_d;
  logic [7:0]        wdata_q, wdata_d;
  logic              start_q, start_d;
  logic [10:0]       len_q, len_d;
  logic [NUM_CH-1:0] done_q, done_d;
  logic [NUM_CH-1:0] err_q, err_d;
  logic              ev_frame, ev_len_err, ev_tmo;

  logic [NUM_CH-1:0] pick_gnt;
  logic [IW-1:0]     pick_idx;
  logic              pick_vld;

  logic [10:0] waddr_a [NUM_CH];
  logic [7:0]  wdata_a [NUM_CH];
  logic [10:0] len_a   [NUM_CH];

  for (genvar k = 0; k < NUM_CH; k++) begin : g_split
    assign waddr_a[k] = ch_waddr[11*k +: 11];
    assign wdata_a[k] = ch_wdata[8*k +: 8];
    assign len_a[k]   = ch_len[11*k +: 11];
  end

  clink_rr_pick #(
    .N  (NUM_CH),
    .IW (IW)
  ) u_pick (
    .req_i (ch_req),
    .rr_i  (rr_q),
    .gnt_o (pick_gnt),
    .idx_o (pick_idx),
    .vld_o (pick_vld)
  );

  logic [15:0] timer_inc;
  logic [10:0] cur_len;
  logic        len_ok;

  assign timer_inc = (timer_q == 16'hFFFF) ? timer_q : timer_q + 16'd1;
  assign cur_len   = len_a[idx_q];
  assign len_ok    = (cur_len != 11'd0) && (cur_len <= MAX_LEN);

  always_comb begin
    state_d    = state_q;
    gnt_d      = gnt_q;
    idx_d      = idx_q;
    rr_d       = rr_q;
    timer_d    = timer_q;
    gap_d      = gap_q;
    wren_d     = 1'b0;
    waddr_d    = waddr_q;
    wdata_d    = wdata_q;
    start_d    = 1'b0;
    len_d      = len_q;
    done_d     = '0;
    err_d      = '0;
    ev_frame   = 1'b0;
    ev_len_err = 1'b0;
    ev_tmo     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (pick_vld) begin
          gnt_d   = pick_gnt;
          idx_d   = pick_idx;
          timer_d = '0;
          state_d = GRANT;
        end
      end
      GRANT: begin
        wren_d  = ch_wren[idx_q];
        waddr_d = waddr_a[idx_q];
        wdata_d = wdata_a[idx_q];
        timer_d = timer_inc;
        if (ch_start[idx_q]) begin
          if (len_ok) begin
            len_d   = cur_len;
            start_d = 1'b1;
            state_d = START;
          end else begin
            err_d      = gnt_q;
            ev_len_err = 1'b1;
            state_d    = GAP;
          end
        end else if (timer_q >= GRANT_TIMEOUT) begin
          err_d   = gnt_q;
          ev_tmo  = 1'b1;
          state_d = GAP;
        end
      end
      START: begin
        timer_d = '0;
        state_d = WAIT_DONE;
      end
      WAIT_DONE: begin
        timer_d = timer_inc;
        if (tx_done) begin
          done_d   = gnt_q;
          ev_frame = 1'b1;
          state_d  = GAP;
        end else if (timer_q >= DONE_TIMEOUT) begin
          err_d   = gnt_q;
          ev_tmo  = 1'b1;
          state_d = GAP;
        end
      end
      GAP: begin
        gap_d = (gap_q != 8'd0) ? gap_q - 8'd1 : 8'd0;
        if (gap_q <= 8'd1) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // Every path into GAP from an owned state is a release.
    if (state_d == GAP && state_q != GAP) begin
      gnt_d  = '0;
      wren_d = 1'b0;
      gap_d  = GAP_CYCLES;
      rr_d   = (idx_q == IW'(NUM_CH - 1)) ? '0 : idx_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      idx_q   <= '0;
      rr_q    <= '0;
      timer_q <= '0;
      gap_q   <= '0;
      wren_q  <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
      start_q <= 1'b0;
      len_q   <= '0;
      done_q  <= '0;
      err_q   <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      idx_q   <= idx_d;
      rr_q    <= rr_d;
      timer_q <= timer_d;
      gap_q   <= gap_d;
      wren_q  <= wren_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
      start_q <= start_d;
      len_q   <= len_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign ch_gnt       = gnt_q;
  assign ch_done      = done_q;
  assign ch_err       = err_q;
  assign tx_buf_wren  = wren_q;
  assign tx_buf_waddr = waddr_q;
  assign tx_buf_wdata = wdata_q;
  assign tx_start     = start_q;
  assign tx_data_len  = len_q;
  assign sched_busy   = (state_q != IDLE);

`ifdef CLINK_SCHED_STATS_EN
  logic [15:0] sf_q, sl_q, st_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sf_q <= '0;
      sl_q <= '0;
      st_q <= '0;
    end else begin
      if (ev_frame && sf_q != 16'hFFFF)   sf_q <= sf_q + 16'd1;
      if (ev_len_err && sl_q != 16'hFFFF) sl_q <= sl_q + 16'd1;
      if (ev_tmo && st_q != 16'hFFFF)     st_q <= st_q + 16'd1;
    end
  end

  assign stat_frames   = sf_q;
  assign stat_len_err  = sl_q;
  assign stat_timeouts = st_q;
`else
  logic unused_ev;
  assign unused_ev = ev_frame ^ ev_len_err ^ ev_tmo;
`endif

endmodule

// File: tb/tb_clink_tx_sched.sv
// Directed bench for clink_tx_sched (two channels, default timeouts).
module tb_clink_tx_sched;

  localparam int N = 2;

  logic           clk = 1'b0;
  logic           reset;
  logic [N-1:0]   ch_req;
  logic [N-1:0]   ch_gnt;
  logic [N-1:0]   ch_wren;
  logic [N*11-1:0] ch_waddr;
  logic [N*8-1:0] ch_wdata;
  logic [N-1:0]   ch_start;
  logic [N*11-1:0] ch_len;
  logic [N-1:0]   ch_done;
  logic [N-1:0]   ch_err;
  logic           tx_buf_wren;
  logic [10:0]    tx_buf_waddr;
  logic [7:0]     tx_buf_wdata;
  logic           tx_start;
  logic [10:0]    tx_data_len;
  logic           tx_done;
  logic           sched_busy;
`ifdef CLINK_SCHED_STATS_EN
  logic [15:0]    stat_frames, stat_len_err, stat_timeouts;
`endif

  int vectors = 0;
  int miscompares = 0;
  int cyc;
  int seen;

  always #5 clk = ~clk;

  clink_tx_sched dut (
    .clk          (clk),
    .reset        (reset),
    .ch_req       (ch_req),
    .ch_gnt       (ch_gnt),
    .ch_wren      (ch_wren),
    .ch_waddr     (ch_waddr),
    .ch_wdata     (ch_wdata),
    .ch_start     (ch_start),
    .ch_len       (ch_len),
    .ch_done      (ch_done),
    .ch_err       (ch_err),
    .tx_buf_wren  (tx_buf_wren),
    .tx_buf_waddr (tx_buf_waddr),
    .tx_buf_wdata (tx_buf_wdata),
    .tx_start     (tx_start),
    .tx_data_len  (tx_data_len),
    .tx_done      (tx_done),
    .sched_busy   (sched_busy)
`ifdef CLINK_SCHED_STATS_EN
    ,
    .stat_frames   (stat_frames),
    .stat_len_err  (stat_len_err),
    .stat_timeouts (stat_timeouts)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_gnt(output int n);
    n = 0;
    while (ch_gnt == '0 && n < 64) begin
      @(negedge clk);
      n++;
    end
    chk("gnt_wait", 32'(ch_gnt != '0), 32'd1);
  endtask

  // Granted channel ch writes nb bytes while the other channel writes
  // junk; the buffer port must show only ch's writes, one cycle late.
  task automatic frame(input int ch, input int nb, input logic [10:0] len,
                       input int ddly);
    int bad;
    logic [10:0] pa;
    logic [7:0] pd;
    int oth;
    bad = 0;
    pa = '0;
    pd = '0;
    oth = 1 - ch;
    for (int i = 0; i <= nb; i++) begin
      @(negedge clk);
      if (i > 0 && (tx_buf_wren !== 1'b1 || tx_buf_waddr !== pa ||
                    tx_buf_wdata !== pd))
        bad++;
      if (i < nb) begin
        pa = 11'(i);
        pd = 8'(i) ^ 8'hA5 ^ 8'(ch);
        ch_wren = '0;
        ch_wren[ch] = 1'b1;
        ch_wren[oth] = 1'b1;
        ch_waddr[ch*11 +: 11] = pa;
        ch_wdata[ch*8 +: 8] = pd;
        ch_waddr[oth*11 +: 11] = 11'd2047 - 11'(i);
        ch_wdata[oth*8 +: 8] = 8'h3C;
      end else begin
        ch_wren = '0;
        ch_start[ch] = 1'b1;
        ch_len[ch*11 +: 11] = len;
      end
    end
    chk("wmirror", 32'(bad), 32'd0);
    @(negedge clk);
    ch_start = '0;
    chk("txstart_hi", 32'(tx_start), 32'd1);
    chk("txlen", 32'(tx_data_len), 32'(len));
    chk("wren_start", 32'(tx_buf_wren), 32'd0);
    @(negedge clk);
    chk("txstart_lo", 32'(tx_start), 32'd0);
    if (ddly > 0) begin
      repeat (ddly - 1) @(negedge clk);
      tx_done = 1'b1;
      @(negedge clk);
      tx_done = 1'b0;
      chk("ch_done", 32'(ch_done), 32'(1 << ch));
      chk("gnt_rel", 32'(ch_gnt), 32'd0);
    end
  endtask

  task automatic len_err(input int ch, input logic [10:0] len,
                         input logic [10:0] prev);
    @(negedge clk);
    ch_start[ch] = 1'b1;
    ch_len[ch*11 +: 11] = len;
    @(negedge clk);
    ch_start = '0;
    chk("lerr_err", 32'(ch_err), 32'(1 << ch));
    chk("lerr_gnt", 32'(ch_gnt), 32'd0);
    chk("lerr_nostart", 32'(tx_start), 32'd0);
    chk("lerr_len", 32'(tx_data_len), 32'(prev));
  endtask

  initial begin
    reset = 1'b1;
    ch_req = '0;
    ch_wren = '0;
    ch_waddr = '0;
    ch_wdata = '0;
    ch_start = '0;
    ch_len = '0;
    tx_done = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_gnt", 32'(ch_gnt), 32'd0);
    chk("rst_busy", 32'(sched_busy), 32'd0);
    chk("rst_wren", 32'(tx_buf_wren), 32'd0);
    chk("rst_start", 32'(tx_start), 32'd0);
    chk("rst_len", 32'(tx_data_len), 32'd0);
    chk("rst_pulses", 32'({ch_done, ch_err}), 32'd0);
    reset = 1'b0;

    // Single full-size frame on ch0
    @(negedge clk);
    ch_req = 2'b01;
    wait_gnt(cyc);
    chk("gnt_ch0", 32'(ch_gnt), 32'd1);
    chk("gnt_lat", 32'(cyc <= 2), 32'd1);
    chk("busy_gnt", 32'(sched_busy), 32'd1);
    ch_req = '0;
    frame(0, 1035, 11'd1035, 200);
    ch_req = 2'b01;
    wait_gnt(cyc);
    chk("gap_min", 32'(cyc >= 16), 32'd1);
    chk("gap_max", 32'(cyc <= 18), 32'd1);
    chk("len_held", 32'(tx_data_len), 32'd1035);

    // Length rejects: zero, then one over the maximum
    len_err(0, 11'd0, 11'd1035);
    wait_gnt(cyc);
    chk("gnt_ch0b", 32'(ch_gnt), 32'd1);
    len_err(0, 11'd1036, 11'd1035);
    ch_req = '0;

    // Both requesting: rr was left at 1, so ch1 goes first
    ch_req = 2'b11;
    wait_gnt(cyc);
    chk("rr_g0", 32'(ch_gnt), 32'b10);
    frame(1, 8, 11'd11, 5);
    wait_gnt(cyc);
    chk("rr_g1", 32'(ch_gnt), 32'b01);
    frame(0, 8, 11'd12, 5);
    wait_gnt(cyc);
    chk("rr_g2", 32'(ch_gnt), 32'b10);
    frame(1, 4, 11'd13, 5);
    wait_gnt(cyc);
    chk("rr_g3", 32'(ch_gnt), 32'b01);
    ch_req = 2'b10;
    frame(0, 4, 11'd14, 5);

    // Grant timeout on ch1
    wait_gnt(cyc);
    chk("tmo_gnt", 32'(ch_gnt), 32'b10);
    ch_req = '0;
    cyc = 0;
    while (ch_err == '0 && cyc < 5000) begin
      @(negedge clk);
      cyc++;
    end
    chk("gtmo_err", 32'(ch_err), 32'b10);
    chk("gtmo_cyc", 32'(cyc >= 4096 && cyc <= 4098), 32'd1);
    chk("gtmo_rel", 32'(ch_gnt), 32'd0);
    ch_req = 2'b11;
    wait_gnt(cyc);
    chk("gtmo_rr0", 32'(ch_gnt), 32'b01);
    ch_req = '0;

    // Done timeout, then a stray tx_done while idle
    frame(0, 2, 11'd40, 0);
    cyc = 1;
    while (ch_err == '0 && cyc < 60100) begin
      @(negedge clk);
      cyc++;
    end
    chk("dtmo_err", 32'(ch_err), 32'b01);
    chk("dtmo_cyc", 32'(cyc >= 60000 && cyc <= 60003), 32'd1);
    chk("dtmo_rel", 32'(ch_gnt), 32'd0);
    repeat (20) @(negedge clk);
    chk("idle_busy", 32'(sched_busy), 32'd0);
    tx_done = 1'b1;
    @(negedge clk);
    tx_done = 1'b0;
    @(negedge clk);
    chk("stray_done", 32'({ch_done, ch_err}), 32'd0);
    chk("stray_busy", 32'(sched_busy), 32'd0);

    // Reset during WAIT_DONE
    ch_req = 2'b10;
    wait_gnt(cyc);
    chk("rst_gnt1", 32'(ch_gnt), 32'b10);
    ch_req = '0;
    frame(1, 3, 11'd20, 0);
    repeat (5) @(negedge clk);
    reset = 1'b1;
    #1;
    chk("mid_gnt", 32'(ch_gnt), 32'd0);
    chk("mid_busy", 32'(sched_busy), 32'd0);
    chk("mid_len", 32'(tx_data_len), 32'd0);
    chk("mid_start", 32'(tx_start | tx_buf_wren), 32'd0);
    repeat (2) @(negedge clk);
    tx_done = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    tx_done = 1'b0;
    seen = 0;
    repeat (20) begin
      @(negedge clk);
      if (ch_done != '0 || ch_err != '0 || sched_busy) seen++;
    end
    chk("post_rst_quiet", 32'(seen), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
